// File: rtl/sprite_mem_port_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_mem_port_scheduler
//
// Purpose:
//   Time-slot scheduler for the single-port sprite memory that feeds
//   rgb_out_generator. Every pixel period is split into PIXEL_CLKS clocks.
//   Slot 0 is reserved for the display read while active_area is high. Every
//   other slot may carry one host write beat, handed over through a req/ack
//   handshake. Read data is captured into a per-pixel register that stays
//   stable across the pixel. The rf_vga_out strobe marks the last clock of
//   each pixel period.
//
// Parameters:
//   PIXEL_CLKS   clocks per pixel period (3..16)
//   SPR_MEM_LAT  sprite memory read latency in clocks (1..PIXEL_CLKS-2)
//   ADDR_W       sprite memory address width
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   active_area      in   visible-area flag (registered upstream)
//   disp_req         in   current pixel lies inside a sprite
//   disp_addr        in   sprite memory address for the current pixel
//   host_req         in   host write request, held until host_ack
//   host_addr        in   host write address
//   host_data        in   host write data {B,G,R}
//   host_ack         out  one-clock pulse once the write is committed
//   mem_addr         out  sprite memory address (combinational mux)
//   mem_wdata        out  sprite memory write data
//   mem_we           out  sprite memory write enable
//   mem_rdata        in   sprite memory read data
//   pix_sprite_data  out  captured sprite pixel, 9'h1FE when no sprite
//   pix_is_sprite    out  captured sprite flag for the current pixel
//   rf_vga_out       out  high in the last clock of each pixel period
// ---------------------------------------------------------------------------
module sprite_mem_port_scheduler #(
  parameter int PIXEL_CLKS  = 4,
  parameter int SPR_MEM_LAT = 1,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_area,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [8:0]        host_data,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8:0]        mem_wdata,
  output logic              mem_we,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        pix_sprite_data,
  output logic              pix_is_sprite,
  output logic              rf_vga_out
);

  localparam int              PH_W      = (PIXEL_CLKS > 1) ? $clog2(PIXEL_CLKS) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PIXEL_CLKS - 1);
  localparam logic [PH_W-1:0] PH_CAP    = PH_W'(SPR_MEM_LAT);
  localparam logic [8:0]      PIX_INVIS = 9'h1FE;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_WRITE = 2'd1,
    H_ACK   = 2'd2
  } hstate_t;

  // Substitutes the transparent code whenever the pixel carries no sprite,
  // so downstream logic never sees stale RAM contents for empty pixels.
  function automatic logic [8:0] pix_select(input logic vld, input logic [8:0] rdata);
    return vld ? rdata : PIX_INVIS;
  endfunction

  logic [PH_W-1:0]   r_phase;
  logic              w_phase_last;
  logic              w_disp_slot;

  hstate_t           r_hstate;
  hstate_t           w_hstate_nxt;

  logic [ADDR_W-1:0] r_host_addr;
  logic [8:0]        r_host_data;

  logic              r_spr_vld_p0;
  logic [8:0]        r_pix_data_p1;
  logic              r_pix_spr_p1;

  // -------------------------------------------------------------------------
  // Pixel phase counter: free-running, independent of active_area so the
  // strobe keeps ticking through blanking.
  // -------------------------------------------------------------------------
  assign w_phase_last = (r_phase == PH_LAST);
  assign w_disp_slot  = (r_phase == '0) && active_area;
  assign rf_vga_out   = w_phase_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (w_phase_last) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Host write FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hstate <= H_IDLE;
    end else begin
      r_hstate <= w_hstate_nxt;
    end
  end

  // Host write FSM: next-state logic. The write beat is the first H_WRITE
  // cycle not claimed by the display slot; a display slot only stalls it.
  always_comb begin
    w_hstate_nxt = r_hstate;
    case (r_hstate)
      H_IDLE:  if (host_req)     w_hstate_nxt = H_WRITE;
      H_WRITE: if (!w_disp_slot) w_hstate_nxt = H_ACK;
      H_ACK:                     w_hstate_nxt = H_IDLE;
      default:                   w_hstate_nxt = H_IDLE;
    endcase
  end

  // Host write FSM: outputs and memory port mux. The display read always
  // owns slot 0, even when no sprite is present, so the read timing seen by
  // the capture stage never depends on host traffic.
  always_comb begin
    mem_addr  = disp_addr;
    mem_wdata = r_host_data;
    mem_we    = 1'b0;
    host_ack  = (r_hstate == H_ACK);
    if (!w_disp_slot && (r_hstate == H_WRITE)) begin
      mem_addr = r_host_addr;
      mem_we   = 1'b1;
    end
  end

  // Request is latched on acceptance, so the host may drop or change its
  // bus once accepted without disturbing the pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_host_addr <= '0;
      r_host_data <= '0;
    end else if ((r_hstate == H_IDLE) && host_req) begin
      r_host_addr <= host_addr;
      r_host_data <= host_data;
    end
  end

  // -------------------------------------------------------------------------
  // Capture p0: remember at the read slot whether this pixel wants sprite data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spr_vld_p0 <= 1'b0;
    end else if (r_phase == '0) begin
      r_spr_vld_p0 <= disp_req && active_area;
    end
  end

  // -------------------------------------------------------------------------
  // Capture p1: take RAM data once the read latency has elapsed; held for
  // the rest of the pixel so it is stable under rf_vga_out.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_data_p1 <= PIX_INVIS;
      r_pix_spr_p1  <= 1'b0;
    end else if (r_phase == PH_CAP) begin
      r_pix_data_p1 <= pix_select(r_spr_vld_p0, mem_rdata);
      r_pix_spr_p1  <= r_spr_vld_p0;
    end
  end

  assign pix_sprite_data = r_pix_data_p1;
  assign pix_is_sprite   = r_pix_spr_p1;

endmodule
